// File: rtl/gate_array_reg_if.sv
// Bus bundle for gate_array_reg: sample-side controls and data in, registered results out.
interface gate_array_reg_if #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  logic [1:0]                mode_in;
  logic                      sticky_in;
  logic                      clear_in;
  logic                      valid_in;
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic                      valid_out;
  logic [CHANNELS-1:0]       Y_out;
  logic [CHANNELS*CNT_W-1:0] rise_cnt_out;

  modport master (
    output mode_in, sticky_in, clear_in, valid_in, data_in,
    input  valid_out, Y_out, rise_cnt_out
  );

  modport slave (
    input  mode_in, sticky_in, clear_in, valid_in, data_in,
    output valid_out, Y_out, rise_cnt_out
  );
endinterface

// File: rtl/gate_array_reg.sv
// Registered multi-channel OR/NOR/AND/NAND reduction array with optional sticky
// hold and per-channel saturating rising-edge counters.
module gate_array_reg #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input logic              clk_in,
  input logic              rst_n_in,
  gate_array_reg_if.slave  bus
);

  localparam logic [1:0] MODE_OR   = 2'b00;
  localparam logic [1:0] MODE_NOR  = 2'b01;
  localparam logic [1:0] MODE_AND  = 2'b10;
  localparam logic [1:0] MODE_NAND = 2'b11;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CHANNELS-1:0] w_f_p0;
  logic [CHANNELS-1:0] w_y_nxt_p0;
  logic [CHANNELS-1:0] w_rise_p0;
  logic [CHANNELS-1:0] r_y_p1;
  logic                r_vld_p1;
  logic [CNT_W-1:0]    r_cnt_p1 [CHANNELS];

  // p0: combinational reduction and next-state for each channel
  always_comb begin
    w_f_p0 = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      unique case (bus.mode_in)
        MODE_OR:   w_f_p0[c] =  (|bus.data_in[c*WIDTH +: WIDTH]);
        MODE_NOR:  w_f_p0[c] = ~(|bus.data_in[c*WIDTH +: WIDTH]);
        MODE_AND:  w_f_p0[c] =  (&bus.data_in[c*WIDTH +: WIDTH]);
        MODE_NAND: w_f_p0[c] = ~(&bus.data_in[c*WIDTH +: WIDTH]);
        default:   w_f_p0[c] = 1'b0;
      endcase
    end
  end

  assign w_y_nxt_p0 = bus.sticky_in ? (r_y_p1 | w_f_p0) : w_f_p0;
  assign w_rise_p0  = ~r_y_p1 & w_y_nxt_p0;

  // p1: registered results, valid flag and counters
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_y_p1   <= '0;
      r_vld_p1 <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) r_cnt_p1[c] <= '0;
    end else if (bus.clear_in) begin
      r_y_p1   <= '0;
      r_vld_p1 <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) r_cnt_p1[c] <= '0;
    end else if (bus.valid_in) begin
      r_y_p1   <= w_y_nxt_p0;
      r_vld_p1 <= 1'b1;
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_rise_p0[c]) r_cnt_p1[c] <= sat_inc(r_cnt_p1[c]);
      end
    end else begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign bus.Y_out     = r_y_p1;
  assign bus.valid_out = r_vld_p1;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_cnt_out
    assign bus.rise_cnt_out[g*CNT_W +: CNT_W] = r_cnt_p1[g];
  end

endmodule

// File: tb/tb_gate_array_reg.sv
// Directed bench for gate_array_reg: default instance plus a CNT_W=2 instance for saturation.
module tb_gate_array_reg;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_in = ~clk_in;

  gate_array_reg_if #(.WIDTH(2), .CHANNELS(4), .CNT_W(8)) if_a ();
  gate_array_reg_if #(.WIDTH(2), .CHANNELS(4), .CNT_W(2)) if_b ();

  gate_array_reg #(.WIDTH(2), .CHANNELS(4), .CNT_W(8)) u_dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (if_a)
  );

  gate_array_reg #(.WIDTH(2), .CHANNELS(4), .CNT_W(2)) u_sat (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (if_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] mode, input logic sticky, input logic clear,
                       input logic valid, input logic [7:0] data);
    if_a.mode_in = mode;   if_b.mode_in = mode;
    if_a.sticky_in = sticky; if_b.sticky_in = sticky;
    if_a.clear_in = clear; if_b.clear_in = clear;
    if_a.valid_in = valid; if_b.valid_in = valid;
    if_a.data_in = data;   if_b.data_in = data;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    logic [1:0] sat_exp [5];
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    // Reset held with all-ones valid data
    drive(2'b00, 1'b0, 1'b0, 1'b1, 8'hFF);
    step(); step();
    chk("rst_y", 32'(if_a.Y_out), 32'h0);
    chk("rst_vld", 32'(if_a.valid_out), 32'h0);
    chk("rst_cnt_a", if_a.rise_cnt_out, 32'h0);
    chk("rst_cnt_b", 32'(if_b.rise_cnt_out), 32'h0);

    rst_n_in = 1'b1;
    step();
    chk("rel_y", 32'(if_a.Y_out), 32'hF);
    chk("rel_vld", 32'(if_a.valid_out), 32'h1);
    chk("rel_cnt_a", if_a.rise_cnt_out, 32'h01010101);
    chk("rel_cnt_b", 32'(if_b.rise_cnt_out), 32'h55);

    // Mode sweep on 8'b11_10_01_00
    drive(2'b00, 1'b0, 1'b0, 1'b1, 8'b11100100); step();
    chk("or_y", 32'(if_a.Y_out), 32'hE);
    drive(2'b01, 1'b0, 1'b0, 1'b1, 8'b11100100); step();
    chk("nor_y", 32'(if_a.Y_out), 32'h1);
    drive(2'b10, 1'b0, 1'b0, 1'b1, 8'b11100100); step();
    chk("and_y", 32'(if_a.Y_out), 32'h8);
    drive(2'b11, 1'b0, 1'b0, 1'b1, 8'b11100100); step();
    chk("nand_y", 32'(if_a.Y_out), 32'h7);
    chk("sweep_vld", 32'(if_a.valid_out), 32'h1);
    chk("sweep_cnt_a", if_a.rise_cnt_out, 32'h02020203);
    chk("sweep_cnt_b", 32'(if_b.rise_cnt_out), 32'hAB);

    // Clear and valid on the same edge: clear wins
    drive(2'b00, 1'b0, 1'b1, 1'b1, 8'hFF); step();
    chk("clr_y", 32'(if_a.Y_out), 32'h0);
    chk("clr_vld", 32'(if_a.valid_out), 32'h0);
    chk("clr_cnt_a", if_a.rise_cnt_out, 32'h0);

    // Sticky OR on channel 0, then a non-sticky overwrite
    drive(2'b00, 1'b1, 1'b0, 1'b1, 8'b00000001); step();
    chk("stk1_y", 32'(if_a.Y_out), 32'h1);
    chk("stk1_vld", 32'(if_a.valid_out), 32'h1);
    drive(2'b00, 1'b1, 1'b0, 1'b1, 8'b00000000); step();
    chk("stk2_y", 32'(if_a.Y_out), 32'h1);
    drive(2'b00, 1'b1, 1'b0, 1'b1, 8'b00000000); step();
    chk("stk3_y", 32'(if_a.Y_out), 32'h1);
    chk("stk3_cnt0", 32'(if_a.rise_cnt_out[7:0]), 32'h1);
    drive(2'b00, 1'b0, 1'b0, 1'b1, 8'b00000000); step();
    chk("nstk_y", 32'(if_a.Y_out), 32'h0);
    chk("nstk_cnt0", 32'(if_a.rise_cnt_out[7:0]), 32'h1);

    // Gaps between valid pulses
    drive(2'b00, 1'b0, 1'b0, 1'b0, 8'hFF); step();
    chk("gap1_vld", 32'(if_a.valid_out), 32'h0);
    chk("gap1_y", 32'(if_a.Y_out), 32'h0);
    drive(2'b00, 1'b0, 1'b0, 1'b1, 8'hFF); step();
    chk("pulse_vld", 32'(if_a.valid_out), 32'h1);
    chk("pulse_y", 32'(if_a.Y_out), 32'hF);
    chk("pulse_cnt_a", if_a.rise_cnt_out, 32'h01010102);
    drive(2'b01, 1'b0, 1'b0, 1'b0, 8'hFF); step();
    chk("gap2_vld", 32'(if_a.valid_out), 32'h0);
    chk("gap2_y", 32'(if_a.Y_out), 32'hF);
    step();
    chk("gap3_y", 32'(if_a.Y_out), 32'hF);
    chk("gap3_cnt_a", if_a.rise_cnt_out, 32'h01010102);

    // Saturation: toggle channel 0 for five rising transitions
    drive(2'b00, 1'b0, 1'b1, 1'b0, 8'h00); step();
    for (int i = 0; i < 5; i++) begin
      drive(2'b00, 1'b0, 1'b0, 1'b1, 8'b00000001); step();
      chk($sformatf("sat_cnt0_%0d", i), 32'(if_b.rise_cnt_out[1:0]), 32'(sat_exp[i]));
      drive(2'b00, 1'b0, 1'b0, 1'b1, 8'b00000000); step();
      chk($sformatf("sat_fall_%0d", i), 32'(if_a.Y_out), 32'h0);
    end
    chk("wide_cnt0", 32'(if_a.rise_cnt_out[7:0]), 32'h5);
    chk("sat_other", 32'(if_b.rise_cnt_out[7:2]), 32'h0);

    // Asynchronous reset mid-stream
    drive(2'b00, 1'b0, 1'b0, 1'b1, 8'hFF); step();
    chk("pre_ar_y", 32'(if_a.Y_out), 32'hF);
    rst_n_in = 1'b0;
    #1;
    chk("ar_y", 32'(if_a.Y_out), 32'h0);
    chk("ar_vld", 32'(if_a.valid_out), 32'h0);
    chk("ar_cnt_a", if_a.rise_cnt_out, 32'h0);
    step();
    rst_n_in = 1'b1;
    step();
    chk("post_ar_y", 32'(if_a.Y_out), 32'hF);
    chk("post_ar_cnt_a", if_a.rise_cnt_out, 32'h01010101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
